sdram_line_loader: RTL and testbench

Parametrised successor to the fixed-size SDRAM-to-VGA line fetcher. On each line-load request from `vga_control` it:
- reads one shifted image line of the selected frame from the SDRAM controller's Avalon-MM slave;
- unpacks 16-bit words into 8-bit pixels;
- pads out-of-image pixels;
- streams the line into the VGA pixel FIFO.

Frame geometry, offset range, address width and read pipelining depth are parameters. Frame ID and offsets are latched per frame, so a frame never tears.

---
 rtl/sdram_line_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_sdram_line_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_line_loader.sv
// SDRAM-to-VGA line loader: fetches one shifted line, unpacks bytes, pads, streams to FIFO.
// Optional SDRAM_LINE_LOADER_WRAP_EN: wrap out-of-range coordinates instead of padding.
module sdram_line_loader #(
  parameter int H_PIX = 1024,
  parameter int V_LINES = 768,
  parameter int LINE_W = 13,
  parameter int OFFSET_W = 8,
  parameter int FRAME_ID_W = 6,
  parameter int ADDR_W = 25,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [7:0] BLANK_PIX = 8'h00
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic [FRAME_ID_W-1:0] iFRAME_ID,
  input  logic iOFFSET_H_SIGN,
  input  logic [OFFSET_W-1:0] iOFFSET_H,
  input  logic iOFFSET_V_SIGN,
  input  logic [OFFSET_W-1:0] iOFFSET_V,
  input  logic [LINE_W-1:0] iVGA_LINE_TO_LOAD,
  input  logic iVGA_LOAD_TO_FIFO_REQ,
  input  logic iWAIT_REQUEST,
  output logic oRD_EN,
  output logic [ADDR_W-1:0] oRD_ADDR,
  input  logic [15:0] iRD_DATA,
  input  logic iRD_DATAVALID,
  output logic [7:0] oFIFO_WDATA,
  output logic oFIFO_WEN,
  input  logic iFIFO_WFULL,
  output logic oBUSY,
  output logic oLINE_DONE,
  output logic oOVERRUN
);

  localparam int HW = H_PIX / 2;
  localparam int PW = $clog2(H_PIX + 1);
  localparam int WW = $clog2(HW + 2);
  localparam int XW = (HW > 1) ? $clog2(HW) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(MAX_OUTSTANDING);

  typedef enum logic [2:0] {IDLE, SETUP, PRE, FETCH, POST, DONE} state_t;

  state_t state;
  logic req_d, edge_c, overrun;
  logic [FRAME_ID_W-1:0] f_lat;
  logic ohs_lat, ovs_lat;
  logic [OFFSET_W-1:0] oh_lat, ov_lat;
  logic [LINE_W-1:0] line_q;
  logic [ADDR_W-1:0] line_base;
  logic [XW-1:0] widx;
  logic [WW-1:0] words_left;
  logic [PW-1:0] pre_left, pix_left, post_left;
  logic hi;
  logic [CW-1:0] inflight, cnt;
  logic [BW-1:0] head, tail;
  logic [15:0] mem [MAX_OUTSTANDING];

  int si, ohv, st, npix, pre, post, words;
  logic [ADDR_W-1:0] base_c;

  always_comb begin
    si = int'(line_q) - (ovs_lat ? -int'(ov_lat) : int'(ov_lat));
    ohv = ohs_lat ? -int'(oh_lat) : int'(oh_lat);
`ifdef SDRAM_LINE_LOADER_WRAP_EN
    si = si % V_LINES;
    if (si < 0) si = si + V_LINES;
    st = (-ohv) % H_PIX;
    if (st < 0) st = st + H_PIX;
    pre = 0;
    post = 0;
    npix = H_PIX;
    // tail burst from st/2, then head burst re-reading the split word
    words = HW - st / 2 + (st + 1) / 2;
`else
    st = 0;
    pre = 0;
    post = 0;
    npix = 0;
    words = 0;
    if (si < 0 || si >= V_LINES || ohv >= H_PIX || -ohv >= H_PIX) begin
      pre = H_PIX;
    end else begin
      if (ohv >= 0) begin
        pre = ohv;
        npix = H_PIX - ohv;
      end else begin
        st = -ohv;
        npix = H_PIX + ohv;
        post = -ohv;
      end
      words = (st + npix + 1) / 2 - st / 2;
    end
`endif
    base_c = ADDR_W'(f_lat) * ADDR_W'(HW * V_LINES)
           + ADDR_W'(si) * ADDR_W'(HW);
  end

  logic avail, rd_c, acc, push, pop, wen_c;
  logic [15:0] cur;
  logic [7:0] wdata_c;

  always_comb begin
    edge_c = iVGA_LOAD_TO_FIFO_REQ && !req_d;
    avail = cnt != '0;
    cur = mem[head];
    wen_c = 1'b0;
    wdata_c = BLANK_PIX;
    unique case (state)
      PRE, POST: wen_c = !iFIFO_WFULL;
      FETCH: begin
        wen_c = avail && !iFIFO_WFULL;
        wdata_c = hi ? cur[15:8] : cur[7:0];
      end
      default: ;
    endcase
    rd_c = state == FETCH && words_left != '0
        && (int'(inflight) + int'(cnt) < MAX_OUTSTANDING);
    acc = rd_c && !iWAIT_REQUEST;
    push = iRD_DATAVALID && state != IDLE && inflight != '0;
    pop = state == FETCH && wen_c && (hi || pix_left == PW'(1));
  end

  function automatic logic [BW-1:0] nxt(input logic [BW-1:0] p);
    return (p == BW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge iCLK) begin
    if (push) mem[tail] <= iRD_DATA;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      req_d <= 1'b0;
      overrun <= 1'b0;
      f_lat <= '0;
      ohs_lat <= 1'b0;
      oh_lat <= '0;
      ovs_lat <= 1'b0;
      ov_lat <= '0;
      line_q <= '0;
      line_base <= '0;
      widx <= '0;
      words_left <= '0;
      pre_left <= '0;
      pix_left <= '0;
      post_left <= '0;
      hi <= 1'b0;
      inflight <= '0;
      cnt <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      req_d <= iVGA_LOAD_TO_FIFO_REQ;
      overrun <= edge_c && state != IDLE;
      inflight <= inflight + CW'(acc) - CW'(push);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (push) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      unique case (state)
        IDLE: if (edge_c) begin
          line_q <= iVGA_LINE_TO_LOAD;
          if (iVGA_LINE_TO_LOAD == '0) begin
            f_lat <= iFRAME_ID;
            ohs_lat <= iOFFSET_H_SIGN;
            oh_lat <= iOFFSET_H;
            ovs_lat <= iOFFSET_V_SIGN;
            ov_lat <= iOFFSET_V;
          end
          state <= SETUP;
        end
        SETUP: begin
          pre_left <= PW'(pre);
          pix_left <= PW'(npix);
          post_left <= PW'(post);
          words_left <= WW'(words);
          widx <= XW'(st / 2);
          hi <= st[0];
          line_base <= base_c;
          if (pre != 0) state <= PRE;
          else if (npix != 0) state <= FETCH;
          else if (post != 0) state <= POST;
          else state <= DONE;
        end
        PRE: if (wen_c) begin
          pre_left <= pre_left - 1'b1;
          if (pre_left == PW'(1))
            state <= (pix_left != '0) ? FETCH : DONE;
        end
        FETCH: begin
          if (acc) begin
            widx <= (widx == XW'(HW - 1)) ? '0 : widx + 1'b1;
            words_left <= words_left - 1'b1;
          end
          if (wen_c) begin
            hi <= ~hi;
            pix_left <= pix_left - 1'b1;
            if (pix_left == PW'(1))
              state <= (post_left != '0) ? POST : DONE;
          end
        end
        POST: if (wen_c) begin
          post_left <= post_left - 1'b1;
          if (post_left == PW'(1)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign oRD_EN = rd_c;
  assign oRD_ADDR = line_base + ADDR_W'(widx);
  assign oFIFO_WEN = wen_c;
  assign oFIFO_WDATA = wdata_c;
  assign oBUSY = state != IDLE && state != DONE;
  assign oLINE_DONE = state == DONE;
  assign oOVERRUN = overrun;

endmodule

// File: tb/tb_sdram_line_loader.sv
// Bench for sdram_line_loader: random Avalon/FIFO backpressure against a
// pixel-level model of the shifted, padded line.
module tb_sdram_line_loader;
  localparam int H = 8, V = 8, LW = 4, OW = 4, FW = 2, AW = 8, MO = 3;
  localparam logic [7:0] BL = 8'hEE;

  logic clk = 1'b0;
  logic rst, req, ohs, ovs, wait_req, rdv, full;
  logic [FW-1:0] frame;
  logic [OW-1:0] oh, ov;
  logic [LW-1:0] line;
  logic [15:0] rd_data;
  logic rd_en, wen, busy, line_done, overrun;
  logic [AW-1:0] addr;
  logic [7:0] wdata;

  always #5 clk = ~clk;

  sdram_line_loader #(
    .H_PIX(H), .V_LINES(V), .LINE_W(LW), .OFFSET_W(OW),
    .FRAME_ID_W(FW), .ADDR_W(AW), .MAX_OUTSTANDING(MO), .BLANK_PIX(BL)
  ) dut (
    .iCLK(clk), .iRST(rst), .iFRAME_ID(frame),
    .iOFFSET_H_SIGN(ohs), .iOFFSET_H(oh),
    .iOFFSET_V_SIGN(ovs), .iOFFSET_V(ov),
    .iVGA_LINE_TO_LOAD(line), .iVGA_LOAD_TO_FIFO_REQ(req),
    .iWAIT_REQUEST(wait_req), .oRD_EN(rd_en), .oRD_ADDR(addr),
    .iRD_DATA(rd_data), .iRD_DATAVALID(rdv),
    .oFIFO_WDATA(wdata), .oFIFO_WEN(wen), .iFIFO_WFULL(full),
    .oBUSY(busy), .oLINE_DONE(line_done), .oOVERRUN(overrun)
  );

  int errors = 0, checks = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // model: latched frame/offsets and expected pixel stream
  int m_f = 0, m_ohv = 0, m_ovv = 0;
  logic [7:0] exp_q[$];
  int exp_reads;

  function automatic int md(int a, int n);
    int r;
    r = a % n;
    return (r < 0) ? r + n : r;
  endfunction

  function automatic logic [15:0] word(int a);
    logic [7:0] lo, hb;
    lo = 8'(a * 13 + 1);
    hb = 8'(a * 7 + 3);
    return {hb, lo};
  endfunction

  // linear source pixel index in SDRAM, or -1 for a padded pixel
  function automatic int src_pix(int L, int x);
    int s, sx;
    s = L - m_ovv;
    sx = x - m_ohv;
`ifdef SDRAM_LINE_LOADER_WRAP_EN
    s = md(s, V);
    sx = md(sx, H);
`else
    if (s < 0 || s >= V || sx < 0 || sx >= H) return -1;
`endif
    return (m_f * V + s) * H + sx;
  endfunction

  function automatic logic [7:0] exp_pix(int L, int x);
    int p;
    logic [15:0] w;
    p = src_pix(L, x);
    if (p < 0) return BL;
    w = word(md(p / 2, 1 << AW));
    return (p % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  function automatic int model_reads(int L);
    int n, prev, p;
    n = 0;
    prev = -1;
    for (int x = 0; x < H; x++) begin
      p = src_pix(L, x);
      if (p >= 0) begin
        if (p / 2 != prev) n++;
        prev = p / 2;
      end
    end
    return n;
  endfunction

  // monitor / slave state
  int cyc = 0, hold_cnt = 0, last_due = 0;
  bit rnd_bp = 0, toggle_full = 0;
  int pend_addr[$], pend_due[$];
  int nwr, reads_cnt, first_addr, first_act, edge_cyc = -10, last_wen = -10;
  int done_cnt = 0, ovr_cnt = 0;
  logic [7:0] line_pix[H];
  bit held_pending = 0, req_prev = 0;
  int held_addr;

  initial begin
    wait_req = 1'b0;
    rdv = 1'b0;
    rd_data = '0;
    full = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        wait_req = 1'b0;
        rdv = 1'b0;
        full = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        last_due = 0;
      end else begin
        wait_req = (hold_cnt > 0) ? 1'b1 :
                   (rnd_bp ? ($urandom_range(0, 3) == 0) : 1'b0);
        full = rnd_bp ? ($urandom_range(0, 3) == 0) :
               (toggle_full ? (cyc % 2 == 1) : 1'b0);
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          rdv = 1'b1;
          rd_data = word(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          rdv = 1'b0;
          rd_data = 16'($urandom);
        end
      end
      #1;
      if (rst) begin
        held_pending = 0;
        req_prev = req;
        continue;
      end
      if (held_pending) begin
        chk(rd_en == 1'b1, "rd_en_held", int'(rd_en), 1);
        chk(int'(addr) == held_addr, "addr_held", int'(addr), held_addr);
      end
      if (rd_en && !wait_req) begin
        int due;
        due = cyc + $urandom_range(1, 4);
        if (due < last_due) due = last_due;
        last_due = due;
        pend_addr.push_back(int'(addr));
        pend_due.push_back(due);
        if (reads_cnt == 0) first_addr = int'(addr);
        reads_cnt++;
        chk(pend_addr.size() <= MO, "in_flight_limit", pend_addr.size(), MO);
      end
      if (rd_en && hold_cnt > 0) hold_cnt--;
      held_pending = rd_en && wait_req;
      held_addr = int'(addr);
      if (wen) begin
        chk(!full, "write_while_full", int'(full), 0);
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_write", int'(wdata), -1);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk(wdata == e, "pixel", int'(wdata), int'(e));
        end
        if (nwr < H) line_pix[nwr] = wdata;
        nwr++;
        last_wen = cyc;
      end
      if ((rd_en || wen) && first_act < 0) first_act = cyc;
      if (req && !req_prev && !busy && !line_done) edge_cyc = cyc;
      if (cyc == edge_cyc + 1) chk(busy == 1'b1, "busy_rise", int'(busy), 1);
      if (line_done) begin
        chk(nwr == H, "pixels_per_line", nwr, H);
        chk(exp_q.size() == 0, "pixels_missing", exp_q.size(), 0);
        chk(!busy, "busy_at_done", int'(busy), 0);
        chk(cyc == last_wen + 1, "done_after_last_write", cyc - last_wen, 1);
        done_cnt++;
      end
      if (overrun) ovr_cnt++;
      req_prev = req;
    end
  end

  int done0, ovr0;

  task automatic start_line(input int L, input int F, input int hs, input int hm,
                            input int vs, input int vm);
    @(negedge clk);
    line = LW'(L);
    frame = FW'(F);
    ohs = hs[0];
    oh = OW'(hm);
    ovs = vs[0];
    ov = OW'(vm);
    req = 1'b1;
    if (L == 0) begin
      m_f = F;
      m_ohv = hs[0] ? -hm : hm;
      m_ovv = vs[0] ? -vm : vm;
    end
    nwr = 0;
    reads_cnt = 0;
    first_addr = -1;
    first_act = -1;
    done0 = done_cnt;
    ovr0 = ovr_cnt;
    exp_reads = model_reads(L);
    for (int x = 0; x < H; x++) exp_q.push_back(exp_pix(L, x));
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic finish_line(input string name);
    int t;
    t = 0;
    while (done_cnt == done0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(done_cnt != done0, {name, "_timeout"}, t, 500);
    repeat (3) @(negedge clk);
    chk(done_cnt - done0 == 1, {name, "_done_pulses"}, done_cnt - done0, 1);
    chk(reads_cnt == exp_reads, {name, "_read_count"}, reads_cnt, exp_reads);
    chk(!busy, {name, "_idle_after"}, int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(rd_en == 1'b0, {name, "_rd_en"}, int'(rd_en), 0);
    chk(addr == '0, {name, "_rd_addr"}, int'(addr), 0);
    chk(wen == 1'b0, {name, "_fifo_wen"}, int'(wen), 0);
    chk(wdata == BL, {name, "_fifo_wdata"}, int'(wdata), int'(BL));
    chk(busy == 1'b0, {name, "_busy"}, int'(busy), 0);
    chk(line_done == 1'b0, {name, "_line_done"}, int'(line_done), 0);
    chk(overrun == 1'b0, {name, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    req = 1'b0;
    line = '0;
    frame = '0;
    ohs = 1'b0;
    oh = '0;
    ovs = 1'b0;
    ov = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // line 5, zero offsets, frame 0; junk inputs must not latch on L!=0
    start_line(5, 3, 1, 7, 0, 2);
    finish_line("plain");
    chk(first_addr == 20, "plain_first_addr", first_addr, 20);
    chk(reads_cnt == 4, "plain_reads", reads_cnt, 4);
    chk(first_act == edge_cyc + 2, "first_read_latency", first_act - edge_cyc, 2);
    chk(line_pix[0] == 8'h05, "plain_pix0", int'(line_pix[0]), 8'h05);
    chk(line_pix[1] == 8'h8F, "plain_pix1", int'(line_pix[1]), 8'h8F);

    start_line(0, 0, 0, 3, 0, 0);
    finish_line("shift_right");
    chk(line_pix[0] == BL, "right_pix0", int'(line_pix[0]), int'(BL));
    chk(line_pix[3] == 8'h01, "right_pix3", int'(line_pix[3]), 8'h01);
    chk(reads_cnt == 3, "right_reads", reads_cnt, 3);

    start_line(0, 0, 1, 3, 0, 0);
    finish_line("shift_left");
    chk(line_pix[0] == 8'h0A, "left_pix0", int'(line_pix[0]), 8'h0A);
    chk(line_pix[7] == BL, "left_pix7", int'(line_pix[7]), int'(BL));
    chk(first_addr == 1, "left_first_addr", first_addr, 1);

    start_line(0, 0, 0, 0, 0, 2);
    finish_line("vshift_l0");
    start_line(1, 2, 1, 5, 1, 5);
    finish_line("vshift_l1");
`ifdef SDRAM_LINE_LOADER_WRAP_EN
    chk(first_addr == 28, "vwrap_first_addr", first_addr, 28);
`else
    chk(reads_cnt == 0, "vblank_reads", reads_cnt, 0);
    chk(line_pix[4] == BL, "vblank_pix4", int'(line_pix[4]), int'(BL));
`endif

    hold_cnt = 5;
    toggle_full = 1'b1;
    start_line(0, 1, 0, 0, 0, 0);
    finish_line("backpressure");
    chk(hold_cnt == 0, "wait_hold_consumed", hold_cnt, 0);
    chk(first_addr == 32, "bp_first_addr", first_addr, 32);
    toggle_full = 1'b0;

    start_line(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    finish_line("overrun");
    chk(ovr_cnt - ovr0 == 1, "overrun_pulses", ovr_cnt - ovr0, 1);

    // reset during FETCH must clear latched frame/offsets too
    start_line(0, 2, 0, 1, 0, 1);
    finish_line("pre_reset");
    start_line(4, 1, 1, 2, 1, 2);
    t = 0;
    while (reads_cnt == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(reads_cnt > 0, "reset_setup_reads", reads_cnt, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_f = 0;
    m_ohv = 0;
    m_ovv = 0;
    start_line(2, 3, 1, 4, 1, 4);
    finish_line("after_reset");
    chk(first_addr == 8, "after_reset_addr", first_addr, 8);
    chk(line_pix[0] == 8'h69, "after_reset_pix0", int'(line_pix[0]), 8'h69);

    rnd_bp = 1'b1;
    repeat (40) begin
      int L;
      L = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      start_line(L, $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 15), $urandom_range(0, 1),
                 $urandom_range(0, 15));
      finish_line("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
